// File: rtl/ring_buffer_rr_scheduler_pkg.sv
// Shared configuration, width helpers and slot record for the ring buffer scheduler.
package ring_sched_pkg;

   localparam int N_REQ           = 4;
   localparam int WIDTH           = 8;
   localparam int DEPTH           = 10;
   localparam int MAX_OUTSTANDING = 4;
   localparam int ID_W            = $clog2(N_REQ);

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_width(input int max_count);
      return $clog2(max_count + 1);
   endfunction

   function automatic int ptr_width(input int slots);
      return (slots > 1) ? $clog2(slots) : 1;
   endfunction

   typedef struct packed {
      logic             valid;
      logic [ID_W-1:0]  id;
      logic [WIDTH-1:0] data;
   } slot_t;

endpackage

// File: rtl/ring_buffer_rr_scheduler_if.sv
// Producer/consumer side bundle of the ring buffer scheduler.
interface ring_sched_if import ring_sched_pkg::*; #(
   parameter int n_req           = N_REQ,
   parameter int width           = WIDTH,
   parameter int depth           = DEPTH,
   parameter int max_outstanding = MAX_OUTSTANDING
) ();

   localparam int ID_W_L = id_width(n_req);
   localparam int CNT_W  = cnt_width(max_outstanding);
   localparam int OCC_W  = cnt_width(depth);

   logic [n_req-1:0]                req_valid;
   logic [n_req-1:0][width-1:0]     req_data;
   logic [n_req-1:0]                req_ready;
   logic                            out_valid;
   logic [ID_W_L-1:0]               out_id;
   logic [width-1:0]                out_data;
   logic [n_req-1:0][CNT_W-1:0]     in_flight;
   logic [OCC_W-1:0]                occupancy;

   modport master (
      output req_valid, req_data,
      input  req_ready, out_valid, out_id, out_data, in_flight, occupancy
   );

   modport slave (
      input  req_valid, req_data,
      output req_ready, out_valid, out_id, out_data, in_flight, occupancy
   );

endinterface

// File: rtl/ring_buffer_rr_scheduler_arbiter.sv
// Round-robin arbiter: rotate eligible so the slot after rr_last sits at bit 0,
// take the lowest set bit, then map the offset back to a requester index.
module rr_arbiter import ring_sched_pkg::*; #(
   parameter int n_req = N_REQ
) (
   input  logic [n_req-1:0]           eligible,
   input  logic [id_width(n_req)-1:0] rr_last,
   output logic [n_req-1:0]           grant
);

   logic [2*n_req-1:0] doubled;
   logic [n_req-1:0]   rotated;
   int                 start;
   int                 pos;
   logic               found;

   always_comb begin
      start   = (int'(rr_last) + 1) % n_req;
      doubled = {eligible, eligible};
      rotated = doubled[start +: n_req];
      found   = 1'b0;
      pos     = 0;
      for (int k = 0; k < n_req; k++) begin
         if (!found && rotated[k]) begin
            pos   = (start + k) % n_req;
            found = 1'b1;
         end
      end
      grant = '0;
      for (int i = 0; i < n_req; i++) begin
         grant[i] = found && (pos == i);
      end
   end

endmodule

// File: rtl/ring_buffer_rr_scheduler.sv
// Fixed-delay ring shared by n_req producers; a beat written under the pointer
// re-emerges exactly depth cycles later tagged with its owner.
module ring_buffer_rr_scheduler import ring_sched_pkg::*; #(
   parameter int n_req           = N_REQ,
   parameter int width           = WIDTH,
   parameter int depth           = DEPTH,
   parameter int max_outstanding = MAX_OUTSTANDING
) (
   input  logic         clk,
   input  logic         rst,
   ring_sched_if.slave  bus
);

   localparam int ID_W_L = id_width(n_req);
   localparam int CNT_W  = cnt_width(max_outstanding);
   localparam int OCC_W  = cnt_width(depth);
   localparam int PTR_W  = ptr_width(depth);

   typedef logic [ID_W_L-1:0] id_t;

   logic [PTR_W-1:0]            ptr;
   logic [depth-1:0]            slot_valid;
   id_t                         slot_id   [depth];
   logic [width-1:0]            slot_data [depth];

   id_t                         rr_last;
   id_t                         grant_id;
   logic [n_req-1:0]            eligible;
   logic [n_req-1:0]            grant;
   logic [n_req-1:0]            release_now;
   logic [n_req-1:0][CNT_W-1:0] in_flight;
   logic [OCC_W-1:0]            occupancy;
   logic                        accept;
   logic                        emerge;

   assign emerge = slot_valid[ptr];

   // A beat leaving this cycle returns its credit in time for the same-cycle grant.
   always_comb begin
      release_now = '0;
      eligible    = '0;
      for (int i = 0; i < n_req; i++) begin
         release_now[i] = emerge && (slot_id[ptr] == id_t'(i));
         eligible[i]    = bus.req_valid[i] &&
                          ((in_flight[i] < CNT_W'(max_outstanding)) || release_now[i]);
      end
   end

   rr_arbiter #(.n_req(n_req)) u_arb (
      .eligible (eligible),
      .rr_last  (rr_last),
      .grant    (grant)
   );

   always_comb begin
      grant_id = '0;
      for (int i = 0; i < n_req; i++) begin
         if (grant[i]) grant_id = id_t'(i);
      end
   end

   assign accept = |grant;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr        <= '0;
         slot_valid <= '0;
         rr_last    <= id_t'(n_req - 1);
         in_flight  <= '0;
         occupancy  <= '0;
      end else begin
         ptr             <= (ptr == PTR_W'(depth - 1)) ? '0 : ptr + 1'b1;
         slot_valid[ptr] <= accept;
         if (accept) rr_last <= grant_id;
         for (int i = 0; i < n_req; i++) begin
            case ({grant[i], release_now[i]})
               2'b10:   in_flight[i] <= in_flight[i] + 1'b1;
               2'b01:   in_flight[i] <= in_flight[i] - 1'b1;
               default: ;
            endcase
         end
         if (accept && !emerge)      occupancy <= occupancy + 1'b1;
         else if (!accept && emerge) occupancy <= occupancy - 1'b1;
      end
   end

   // Payload and tag are qualified by slot_valid, so they carry no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         slot_id[ptr]   <= grant_id;
         slot_data[ptr] <= bus.req_data[grant_id];
      end
   end

   assign bus.req_ready = grant;
   assign bus.out_valid = emerge;
   assign bus.out_id    = slot_id[ptr];
   assign bus.out_data  = slot_data[ptr];
   assign bus.in_flight = in_flight;
   assign bus.occupancy = occupancy;

endmodule
